inst_pipe_regs: RTL and testbench
=================================

// Module: inst_pipe_regs
// PURPOSE
//  Two-stage instruction holding register between instruction fetch and decode.
//  Stage 1 (fetch register, PIPO1 behaviour) captures the instruction word read from memory.
//  Stage 2 (decode register, dff behaviour) captures stage 1 and drives the decoder field taps.
//  Each stage has its own load enable and synchronous flush, used by hazard stalls and branch flushes.
// PARAMETERS
//  WIDTH     32   instruction word width in bits
//  CLR_VAL   0    value both stages take on reset or flush (WIDTH bits)
// PORTS
//  clk           in   1      single clock; all state updates on rising edge
//  clr           in   1      reset, synchronous, active-high; clears both stages
//  ldInst        in   1      stage-1 load enable
//  clrInst       in   1      stage-1 synchronous flush
//  ldDecodeInst  in   1      stage-2 load enable
//  clrDecodeInst in   1      stage-2 synchronous flush
//  readInst      in   WIDTH  instruction word from instruction memory
//  fetchInst     out  WIDTH  stage-1 contents (registered)
//  fetchValid    out  1      stage 1 holds a loaded, unflushed word
//  decodeInst    out  WIDTH  stage-2 contents (registered); feeds opcode/rd/rs1/rs2/imm taps
//  decodeValid   out  1      stage 2 holds a valid word
// BEHAVIOUR
//  - Reset: clr=1 at a rising edge -> fetchInst=decodeInst=CLR_VAL, fetchValid=decodeValid=0.
//  - Stage-1 priority per edge: clr > clrInst > ldInst > hold.
//    clrInst: fetchInst<=CLR_VAL, fetchValid<=0. ldInst: fetchInst<=readInst, fetchValid<=1.
//  - Stage-2 priority per edge: clr > clrDecodeInst > ldDecodeInst > hold.
//    ldDecodeInst: decodeInst<=fetchInst, decodeValid<=fetchValid (pre-edge values).
//  - Both stages sample pre-edge values: ldInst and ldDecodeInst together shift the pipe by one.
//  - Latency readInst -> decodeInst is 2 edges with both loads high.
//  - Stall: ld low -> stage holds value and valid indefinitely.
//  - Flush with load in the same cycle: flush wins, and the word presented is dropped.
//  - Flushing stage 1 while loading stage 2 moves the old stage-1 word into stage 2.
//  - Flushing stage 2 while loading stage 1 clears stage 2 only.
//  - Outputs come straight from flops; there is no combinational path from inputs to outputs.
//  - clr asserted mid-stream overrides every other control for that edge.
//  - No X propagation after the first reset edge.
//  - The data path is pure storage. There is no arithmetic and no width conversion.
// STRUCTURE
//  - Shared package: WIDTH default, CLR_VAL, and the instruction field bit positions:
//    opcode[31:27], iOrReg[26], rd[25:22], rs1[21:18], rs2[17:14], modifier[17:16], imm[15:0].
//  - One natural sub-module, ld_clr_reg #(WIDTH): q, d, ld, clr, clk.
//    It has priority clr > ld > hold and is instantiated twice for data and twice (WIDTH=1) for valid.
//    clr input = clr | stage flush.
// TESTING
//  1. Reset: clr=1 for 1 edge with readInst=32'hDEADBEEF, ldInst=1 -> all outputs 0, valids 0.
//  2. Pipe shift: ldInst=ldDecodeInst=1, readInst=A,B,C on successive edges (A=32'h08400001)
//     -> decodeInst=A two edges after A is presented, then B, then C; decodeValid=1 from that edge.
//  3. Stall: after fetchInst=32'h12345678, hold ldInst=0 for 5 edges with readInst changing
//     -> fetchInst stays 32'h12345678 and fetchValid stays 1.
//  4. Flush priority: clrInst=1, ldInst=1, readInst=32'hFFFFFFFF -> fetchInst=0, fetchValid=0.
//     Same edge ldDecodeInst=1 -> decodeInst takes the old fetchInst.
//  5. Decode flush: clrDecodeInst=1, ldDecodeInst=1 -> decodeInst=0, decodeValid=0.
//     Stage 1 is unaffected and loads readInst if ldInst=1.
//  6. Mid-stream reset: pipe full (decodeInst=32'hA5A5A5A5), assert clr with all ld/clr high
//     -> next edge both stages 0. The edge after clr drops, stage 1 loads readInst.

Source files
------------

// File: rtl/inst_pipe_regs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : inst_pipe_regs_pkg                                                |
// | Brief  : Shared width, clear value and instruction field layout.           |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
package inst_pipe_regs_pkg;

    localparam int c_width = 32;
    localparam logic [c_width-1:0] c_clr_val = '0;

    localparam int c_opcode_msb   = 31;
    localparam int c_opcode_lsb   = 27;
    localparam int c_iorreg_bit   = 26;
    localparam int c_rd_msb       = 25;
    localparam int c_rd_lsb       = 22;
    localparam int c_rs1_msb      = 21;
    localparam int c_rs1_lsb      = 18;
    localparam int c_rs2_msb      = 17;
    localparam int c_rs2_lsb      = 14;
    localparam int c_modifier_msb = 17;
    localparam int c_modifier_lsb = 16;
    localparam int c_imm_msb      = 15;
    localparam int c_imm_lsb      = 0;

    // rs2, modifier and imm overlap, so fields are unpacked by a function
    typedef struct packed {
        logic [4:0]  opcode;
        logic        iOrReg;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [1:0]  modifier;
        logic [15:0] imm;
    } inst_fields_t;

    function automatic inst_fields_t get_fields(input logic [c_width-1:0] inst);
        inst_fields_t f;
        f.opcode   = inst[c_opcode_msb:c_opcode_lsb];
        f.iOrReg   = inst[c_iorreg_bit];
        f.rd       = inst[c_rd_msb:c_rd_lsb];
        f.rs1      = inst[c_rs1_msb:c_rs1_lsb];
        f.rs2      = inst[c_rs2_msb:c_rs2_lsb];
        f.modifier = inst[c_modifier_msb:c_modifier_lsb];
        f.imm      = inst[c_imm_msb:c_imm_lsb];
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_pipe_regs_ld_clr_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ld_clr_reg                                                        |
// | Brief  : Register with synchronous clear and load enable (clr > ld > hold).|
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module ld_clr_reg
    import inst_pipe_regs_pkg::*;
#(
    parameter int               WIDTH   = c_width,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= CLR_VAL;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/inst_pipe_regs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : inst_pipe_regs                                                    |
// | Brief  : Fetch and decode instruction holding registers with valid flags.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module inst_pipe_regs
    import inst_pipe_regs_pkg::*;
#(
    parameter int               WIDTH   = c_width,
    parameter logic [WIDTH-1:0] CLR_VAL = WIDTH'(c_clr_val)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ldInst,
    input  logic             clrInst,
    input  logic             ldDecodeInst,
    input  logic             clrDecodeInst,
    input  logic [WIDTH-1:0] readInst,
    output logic [WIDTH-1:0] fetchInst,
    output logic             fetchValid,
    output logic [WIDTH-1:0] decodeInst,
    output logic             decodeValid
);

    logic w_fetch_clr;
    logic w_decode_clr;

    // Global reset folds into each stage's flush so clr always wins
    assign w_fetch_clr  = clr | clrInst;
    assign w_decode_clr = clr | clrDecodeInst;

    ld_clr_reg #(.WIDTH(WIDTH), .CLR_VAL(CLR_VAL)) u_fetch_data (
        .clk (clk),
        .clr (w_fetch_clr),
        .ld  (ldInst),
        .d   (readInst),
        .q   (fetchInst)
    );

    ld_clr_reg #(.WIDTH(1), .CLR_VAL(1'b0)) u_fetch_valid (
        .clk (clk),
        .clr (w_fetch_clr),
        .ld  (ldInst),
        .d   (1'b1),
        .q   (fetchValid)
    );

    ld_clr_reg #(.WIDTH(WIDTH), .CLR_VAL(CLR_VAL)) u_decode_data (
        .clk (clk),
        .clr (w_decode_clr),
        .ld  (ldDecodeInst),
        .d   (fetchInst),
        .q   (decodeInst)
    );

    ld_clr_reg #(.WIDTH(1), .CLR_VAL(1'b0)) u_decode_valid (
        .clk (clk),
        .clr (w_decode_clr),
        .ld  (ldDecodeInst),
        .d   (fetchValid),
        .q   (decodeValid)
    );

endmodule
`default_nettype wire

// File: tb/tb_inst_pipe_regs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_inst_pipe_regs                                                 |
// | Brief  : Directed bench for the fetch/decode instruction registers.        |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_inst_pipe_regs;
    import inst_pipe_regs_pkg::*;

    logic        clk;
    logic        clr;
    logic        ldInst;
    logic        clrInst;
    logic        ldDecodeInst;
    logic        clrDecodeInst;
    logic [31:0] readInst;
    logic [31:0] fetchInst;
    logic        fetchValid;
    logic [31:0] decodeInst;
    logic        decodeValid;

    int vectors;
    int miscompares;

    inst_pipe_regs #(.WIDTH(32), .CLR_VAL(32'h0)) dut (
        .clk           (clk),
        .clr           (clr),
        .ldInst        (ldInst),
        .clrInst       (clrInst),
        .ldDecodeInst  (ldDecodeInst),
        .clrDecodeInst (clrDecodeInst),
        .readInst      (readInst),
        .fetchInst     (fetchInst),
        .fetchValid    (fetchValid),
        .decodeInst    (decodeInst),
        .decodeValid   (decodeValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctl(input logic c, input logic ci, input logic li,
                           input logic cd, input logic ld, input logic [31:0] ri);
        clr           = c;
        clrInst       = ci;
        ldInst        = li;
        clrDecodeInst = cd;
        ldDecodeInst  = ld;
        readInst      = ri;
    endtask

    task automatic test_reset();
        set_ctl(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
        tick();
        vectors++;
        if (fetchInst !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_fetchInst: got %h expected %h", fetchInst, 32'h0);
        end
        vectors++;
        if (fetchValid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_fetchValid: got %b expected %b", fetchValid, 1'b0);
        end
        vectors++;
        if (decodeInst !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_decodeInst: got %h expected %h", decodeInst, 32'h0);
        end
        vectors++;
        if (decodeValid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_decodeValid: got %b expected %b", decodeValid, 1'b0);
        end
    endtask

    task automatic test_pipe_shift();
        inst_fields_t f;
        set_ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h08400001);
        tick();
        vectors++;
        if (fetchInst !== 32'h08400001 || fetchValid !== 1'b1) begin
            miscompares++;
            $display("FAIL shift_fetch_A: got %h/%b expected %h/%b", fetchInst, fetchValid, 32'h08400001, 1'b1);
        end
        vectors++;
        if (decodeValid !== 1'b0) begin
            miscompares++;
            $display("FAIL shift_decodeValid_early: got %b expected %b", decodeValid, 1'b0);
        end
        readInst = 32'h0BADC0DE;
        tick();
        vectors++;
        if (decodeInst !== 32'h08400001 || decodeValid !== 1'b1) begin
            miscompares++;
            $display("FAIL shift_decode_A: got %h/%b expected %h/%b", decodeInst, decodeValid, 32'h08400001, 1'b1);
        end
        f = get_fields(decodeInst);
        vectors++;
        if (f.opcode !== 5'd1 || f.iOrReg !== 1'b0 || f.rd !== 4'd1 || f.rs1 !== 4'd0 || f.imm !== 16'h0001) begin
            miscompares++;
            $display("FAIL shift_fields_A: got op=%h i=%b rd=%h rs1=%h imm=%h expected op=01 i=0 rd=1 rs1=0 imm=0001",
                     f.opcode, f.iOrReg, f.rd, f.rs1, f.imm);
        end
        readInst = 32'hCAFEF00D;
        tick();
        vectors++;
        if (decodeInst !== 32'h0BADC0DE || fetchInst !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL shift_B: got dec=%h fet=%h expected dec=%h fet=%h", decodeInst, fetchInst, 32'h0BADC0DE, 32'hCAFEF00D);
        end
        ldInst = 1'b0;
        tick();
        vectors++;
        if (decodeInst !== 32'hCAFEF00D || decodeValid !== 1'b1) begin
            miscompares++;
            $display("FAIL shift_C: got %h/%b expected %h/%b", decodeInst, decodeValid, 32'hCAFEF00D, 1'b1);
        end
    endtask

    task automatic test_stall();
        set_ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h12345678);
        tick();
        ldInst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            readInst = 32'h1000_0000 + 32'(i * 32'h0101_0101);
            tick();
            vectors++;
            if (fetchInst !== 32'h12345678 || fetchValid !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_fetch[%0d]: got %h/%b expected %h/%b", i, fetchInst, fetchValid, 32'h12345678, 1'b1);
            end
            vectors++;
            if (decodeInst !== 32'hCAFEF00D || decodeValid !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_decode[%0d]: got %h/%b expected %h/%b", i, decodeInst, decodeValid, 32'hCAFEF00D, 1'b1);
            end
        end
    endtask

    task automatic test_flush_priority();
        set_ctl(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF);
        tick();
        vectors++;
        if (fetchInst !== 32'h0 || fetchValid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_fetch: got %h/%b expected %h/%b", fetchInst, fetchValid, 32'h0, 1'b0);
        end
        vectors++;
        if (decodeInst !== 32'h12345678 || decodeValid !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_decode_takes_old: got %h/%b expected %h/%b", decodeInst, decodeValid, 32'h12345678, 1'b1);
        end
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h55555555);
        tick();
        vectors++;
        if (decodeInst !== 32'h0 || decodeValid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_bubble: got %h/%b expected %h/%b", decodeInst, decodeValid, 32'h0, 1'b0);
        end
    endtask

    task automatic test_decode_flush();
        set_ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0BADF00D);
        tick();
        readInst = 32'h13572468;
        tick();
        vectors++;
        if (decodeInst !== 32'h0BADF00D || decodeValid !== 1'b1) begin
            miscompares++;
            $display("FAIL dflush_setup: got %h/%b expected %h/%b", decodeInst, decodeValid, 32'h0BADF00D, 1'b1);
        end
        set_ctl(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h2468ACE0);
        tick();
        vectors++;
        if (decodeInst !== 32'h0 || decodeValid !== 1'b0) begin
            miscompares++;
            $display("FAIL dflush_decode: got %h/%b expected %h/%b", decodeInst, decodeValid, 32'h0, 1'b0);
        end
        vectors++;
        if (fetchInst !== 32'h2468ACE0 || fetchValid !== 1'b1) begin
            miscompares++;
            $display("FAIL dflush_fetch: got %h/%b expected %h/%b", fetchInst, fetchValid, 32'h2468ACE0, 1'b1);
        end
    endtask

    task automatic test_midstream_reset();
        set_ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA5A5A5A5);
        tick();
        readInst = 32'h5A5A5A5A;
        tick();
        vectors++;
        if (decodeInst !== 32'hA5A5A5A5 || fetchInst !== 32'h5A5A5A5A) begin
            miscompares++;
            $display("FAIL mreset_full: got dec=%h fet=%h expected dec=%h fet=%h", decodeInst, fetchInst, 32'hA5A5A5A5, 32'h5A5A5A5A);
        end
        set_ctl(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h77777777);
        tick();
        vectors++;
        if (fetchInst !== 32'h0 || fetchValid !== 1'b0 || decodeInst !== 32'h0 || decodeValid !== 1'b0) begin
            miscompares++;
            $display("FAIL mreset_clear: got %h/%b %h/%b expected 0/0 0/0", fetchInst, fetchValid, decodeInst, decodeValid);
        end
        set_ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h3C3C3C3C);
        tick();
        vectors++;
        if (fetchInst !== 32'h3C3C3C3C || fetchValid !== 1'b1) begin
            miscompares++;
            $display("FAIL mreset_reload: got %h/%b expected %h/%b", fetchInst, fetchValid, 32'h3C3C3C3C, 1'b1);
        end
        vectors++;
        if (decodeInst !== 32'h0 || decodeValid !== 1'b0) begin
            miscompares++;
            $display("FAIL mreset_decode_bubble: got %h/%b expected %h/%b", decodeInst, decodeValid, 32'h0, 1'b0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        test_reset();
        test_pipe_shift();
        test_stall();
        test_flush_priority();
        test_decode_flush();
        test_midstream_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
